// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: arbitration state encoding.
// No logic; imported by the arbiter top and its priority-search helper.
// Not applicable: holds no datapath and applies no backpressure.
package rr_mux_arbiter_pkg;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Requester count for a given select width.
    function automatic int num_req(input int address_width);
        return 1 << address_width;
    endfunction

endpackage

// File: rtl/mux.sv
// Generic parameterised N:1 word selector over a packed input bus.
// Latency: combinational, zero cycles.
// Backpressure: none; it is a pure selector.
module mux #(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 2
) (
    input  logic [WIDTH*(2**SEL_WIDTH)-1:0] din,
    input  logic [SEL_WIDTH-1:0]            sel,
    output logic [WIDTH-1:0]                dout
);

    assign dout = din[sel*WIDTH +: WIDTH];

endmodule

// File: rtl/rr_mux_arbiter_pick.sv
// Round-robin priority search: first set request bit at or after ptr, modulo N.
// Latency: combinational, zero cycles.
// Backpressure: none; found=0 when no request bit is set.
module rr_mux_arbiter_pick #(
    parameter int ADDRESS_WIDTH = 2
) (
    input  logic [(2**ADDRESS_WIDTH)-1:0] req,
    input  logic [ADDRESS_WIDTH-1:0]      ptr,
    output logic                          found,
    output logic [ADDRESS_WIDTH-1:0]      idx
);

    localparam int N = 2**ADDRESS_WIDTH;

    logic [ADDRESS_WIDTH-1:0] cand;

    // Walk offsets from far to near so the closest requester to ptr wins;
    // the select-width addition wraps modulo N for free.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr + ADDRESS_WIDTH'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N:1 selector; grants lock for multi-beat packets.
// Latency: one cycle from accept (req_valid & req_ready) to out_valid.
// Backpressure: req_ready is all-zero while out_valid && !out_ready; outputs hold.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [(2**ADDRESS_WIDTH)-1:0]            req_valid,
    input  logic [(2**ADDRESS_WIDTH)-1:0]            req_last,
    input  logic [DATA_WIDTH*(2**ADDRESS_WIDTH)-1:0] req_data,
    output logic [(2**ADDRESS_WIDTH)-1:0]            req_ready,
    output logic                                     out_valid,
    output logic [DATA_WIDTH-1:0]                    out_data,
    output logic [ADDRESS_WIDTH-1:0]                 out_grant,
    output logic                                     out_last,
    input  logic                                     out_ready
);

    localparam int N = num_req(ADDRESS_WIDTH);

    arb_state_t               state;
    logic [ADDRESS_WIDTH-1:0] rr_ptr;
    logic [ADDRESS_WIDTH-1:0] lock_idx;

    logic                     slot_free;
    logic                     pick_found;
    logic [ADDRESS_WIDTH-1:0] pick_idx;
    logic [ADDRESS_WIDTH-1:0] grant_idx;
    logic                     gnt_en;
    logic                     accept;
    logic [ADDRESS_WIDTH-1:0] next_ptr;
    logic [DATA_WIDTH-1:0]    sel_data;

    assign slot_free = !out_valid || out_ready;

    rr_mux_arbiter_pick #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A locked packet owns the slot even while its requester is idle.
    always_comb begin
        grant_idx = pick_idx;
        gnt_en    = 1'b0;
        if (state == ST_LOCKED) begin
            grant_idx = lock_idx;
            gnt_en    = slot_free;
        end else begin
            gnt_en    = slot_free && pick_found;
        end
        req_ready = '0;
        if (gnt_en && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept   = gnt_en && !rst && req_valid[grant_idx];
    assign next_ptr = grant_idx + ADDRESS_WIDTH'(1);

    mux #(
        .WIDTH     (DATA_WIDTH),
        .SEL_WIDTH (ADDRESS_WIDTH)
    ) u_mux (
        .din  (req_data),
        .sel  (grant_idx),
        .dout (sel_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ARB;
            rr_ptr    <= '0;
            lock_idx  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_grant <= grant_idx;
                out_last  <= req_last[grant_idx];
                if (req_last[grant_idx]) begin
                    state  <= ST_ARB;
                    rr_ptr <= next_ptr;
                end else begin
                    state    <= ST_LOCKED;
                    lock_idx <= grant_idx;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (DATA_WIDTH=8, ADDRESS_WIDTH=2).
module tb_rr_mux_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_grant;
    logic        out_last;
    logic        out_ready;

    int n_chk;
    int n_bad;

    rr_mux_arbiter #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_grant (out_grant),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_dat(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] g,
                           input logic [7:0] d, input logic l);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".grant"}, 32'(out_grant), 32'(g));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".last"},  32'(out_last),  32'(l));
    endtask

    logic [7:0] fair_dat [4];
    logic [1:0] alt_g [4];

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        fair_dat  = '{8'h10, 8'h21, 8'h32, 8'h43};
        alt_g     = '{2'd3, 2'd0, 2'd3, 2'd0};

        // reset and idle
        tick();
        #1 chk("rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_valid", 32'(out_valid), 32'h0);
            chk("idle_data",  32'(out_data),  32'h0);
            chk("idle_ready", 32'(req_ready), 32'h0);
        end

        // fairness: all four single-beat, grants 0,1,2,3,0
        for (int i = 0; i < 4; i++) set_dat(i, fair_dat[i]);
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        #1 chk("fair_ready0", 32'(req_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("fair", 1'b1, 2'(i % 4), fair_dat[i % 4], 1'b1);
            #1 chk("fair_ready", 32'(req_ready), 32'(1 << ((i + 1) % 4)));
        end
        req_valid = '0;
        tick();
        chk("fair_drain", 32'(out_valid), 32'h0);

        // lock: requester 2 three beats with a gap, requester 1 waiting
        set_dat(1, 8'h21);
        set_dat(2, 8'hB0);
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        #1 chk("lock_ready0", 32'(req_ready), 32'h4);
        tick();
        chk_out("lock_b0", 1'b1, 2'd2, 8'hB0, 1'b0);
        set_dat(2, 8'hB1);
        req_valid = 4'b0110;
        #1 chk("lock_ready1", 32'(req_ready), 32'h4);
        tick();
        chk_out("lock_b1", 1'b1, 2'd2, 8'hB1, 1'b0);
        req_valid = 4'b0010;
        #1 chk("lock_gap_ready", 32'(req_ready), 32'h4);
        tick();
        chk("lock_gap_valid", 32'(out_valid), 32'h0);
        set_dat(2, 8'hB2);
        req_valid = 4'b0110;
        req_last  = 4'b0110;
        #1 chk("lock_ready2", 32'(req_ready), 32'h4);
        tick();
        chk_out("lock_b2", 1'b1, 2'd2, 8'hB2, 1'b1);
        #1 chk("lock_rel_ready", 32'(req_ready), 32'h2);
        tick();
        chk_out("lock_r1", 1'b1, 2'd1, 8'h21, 1'b1);
        req_valid = '0;
        tick();
        chk("lock_drain", 32'(out_valid), 32'h0);

        // backpressure: A5 held for four stalled cycles, then 5A once
        set_dat(2, 8'hA5);
        req_valid = 4'b0100;
        req_last  = 4'b0100;
        tick();
        chk_out("bp_first", 1'b1, 2'd2, 8'hA5, 1'b1);
        set_dat(2, 8'h5A);
        out_ready = 1'b0;
        #1 chk("bp_ready0", 32'(req_ready), 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_out("bp_hold", 1'b1, 2'd2, 8'hA5, 1'b1);
            chk("bp_hold_ready", 32'(req_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'h4);
        tick();
        chk_out("bp_next", 1'b1, 2'd2, 8'h5A, 1'b1);
        req_valid = '0;
        tick();
        chk("bp_no_dup", 32'(out_valid), 32'h0);

        // wrap: requesters 3 and 0 alternate
        set_dat(3, 8'h43);
        set_dat(0, 8'h10);
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        #1 chk("wrap_ready0", 32'(req_ready), 32'h8);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("wrap", 1'b1, alt_g[i], (alt_g[i] == 2'd3) ? 8'h43 : 8'h10, 1'b1);
            #1 chk("wrap_ready", 32'(req_ready), (alt_g[i] == 2'd3) ? 32'h1 : 32'h8);
        end
        req_valid = '0;
        tick();

        // mid-packet reset during requester 1's second beat
        set_dat(1, 8'hC0);
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        #1 chk("mrst_ready0", 32'(req_ready), 32'h2);
        tick();
        chk_out("mrst_b0", 1'b1, 2'd1, 8'hC0, 1'b0);
        set_dat(1, 8'hC1);
        rst = 1'b1;
        #1 chk("mrst_ready_forced", 32'(req_ready), 32'h0);
        tick();
        chk_out("mrst_after", 1'b0, 2'd0, 8'h00, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_dat(i, fair_dat[i]);
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        #1 chk("mrst_arb_ready", 32'(req_ready), 32'h1);
        tick();
        chk_out("mrst_first", 1'b1, 2'd0, 8'h10, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
